// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration.
package dmem_arb_pkg;

    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W       = 3;
    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic                     we;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
        logic [DMEM_DATA_W/8-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter.
// slave = arbiter view, master = requester/memory view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [DATA_W/8-1:0] req0_be;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [DATA_W/8-1:0] req1_be;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] memory_data;

    logic              mem_en;
    logic              mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr,
        input  req0_wdata, req0_be,
        input  req1_valid, req1_we, req1_addr,
        input  req1_wdata, req1_be,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, memory_data,
        output mem_en, mem_we, mem_be,
        output mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr,
        output req0_wdata, req0_be,
        output req1_valid, req1_we, req1_addr,
        output req1_wdata, req1_be,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, memory_data,
        input  mem_en, mem_we, mem_be,
        input  mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_grant.sv
// One-hot grant between the two requesters, only while idle.
// DMEM_ARB_RR_EN: contention goes to the port not granted last.
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  logic       v0,
    input  logic       v1,
    input  logic       idle,
`ifdef DMEM_ARB_RR_EN
    input  port_id_t   last,
`endif
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (idle) begin
            unique case (1'b1)
                (v0 && !v1): gnt = 2'b01;
                (!v0 && v1): gnt = 2'b10;
`ifdef DMEM_ARB_RR_EN
                (v0 && v1):  gnt = last ? 2'b01 : 2'b10;
`else
                (v0 && v1):  gnt = 2'b01;
`endif
                default:     gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port fixed-latency data memory.
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);

    arb_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    mem_req_t          req0_f, req1_f;
    port_id_t          port_q, port_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        gnt;
    logic              idle, hs, issue, rd_last;

    // Ready is forced low while reset is asserted
    assign idle    = (state_q == IDLE) && rst_n;
    assign hs      = |gnt;
    assign issue   = (state_q == ISSUE);
    assign rd_last = (state_q == WAIT) && (cnt_q == CNT_W'(1));

    assign req0_f = '{we: bus.req0_we, addr: bus.req0_addr,
                      wdata: bus.req0_wdata, be: bus.req0_be};
    assign req1_f = '{we: bus.req1_we, addr: bus.req1_addr,
                      wdata: bus.req1_wdata, be: bus.req1_be};

`ifdef DMEM_ARB_RR_EN
    port_id_t last_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (hs) begin
            last_q <= gnt[1];
        end
    end
`endif

    dmem_arb_grant u_grant (
        .v0   (bus.req0_valid),
        .v1   (bus.req1_valid),
        .idle (idle),
`ifdef DMEM_ARB_RR_EN
        .last (last_q),
`endif
        .gnt  (gnt)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    req_d   = gnt[1] ? req1_f : req0_f;
                    port_d  = gnt[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_W'(MEM_LAT);
                state_d = req_q.we ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (rd_last) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            port_q  <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            if (rd_last) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.req0_ready  = gnt[0];
    assign bus.req1_ready  = gnt[1];
    assign bus.rsp0_valid  = (state_q == RESP) && !port_q;
    assign bus.rsp1_valid  = (state_q == RESP) && port_q;
    assign bus.memory_data = rdata_q;

    assign bus.mem_en    = issue;
    assign bus.mem_we    = issue && req_q.we;
    assign bus.mem_be    = issue ? req_q.be : '0;
    assign bus.mem_addr  = issue ? ADDR_W'(req_q.addr) : '0;
    assign bus.mem_wdata = issue ? req_q.wdata : '0;

endmodule
